icache_responder: RTL and testbench

- Direct-mapped, read-only instruction cache.
- It is the cache end of the datapath-cache interface: it accepts fetch requests (imemREN/imemaddr) and returns ihit/imemload.
- On a miss it issues word reads to the memory controller (iREN/iaddr, iwait/iload).
- Sits between the pipelined datapath's fetch stage and the memory controller's instruction port.

---
 rtl/icache_responder_if.sv | 22 ++
 rtl/icache_responder.sv | 123 ++++++++++++
 tb/tb_icache_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// Datapath fetch port and memory-controller read port of the instruction cache.
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        inv;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, inv, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, inv, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache, one word per line, blocking miss FSM.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_responder #(
  parameter int unsigned SETS = 16
) (
  input  logic               CLK,
  input  logic               RST,
  icache_responder_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e            state_q, state_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              hit, fill;
  logic              ihit, iren;
  logic [31:0]       imemload, iaddr;

  assign req_idx  = bus.imemaddr[2 +: IDX_W];
  assign req_tag  = bus.imemaddr[31 -: TAG_W];
  assign fill_idx = miss_addr_q[2 +: IDX_W];
  assign fill_tag = miss_addr_q[31 -: TAG_W];

  assign hit = bus.imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag)
               && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = '0;
    iren        = 1'b0;
    iaddr       = '0;
    fill        = 1'b0;
    unique case (state_q)
      StIdle: begin
        ihit = hit;
        if (hit) imemload = data_q[req_idx];
        if (bus.imemREN && !hit) begin
          miss_addr_d = {bus.imemaddr[31:2], 2'b00};
          state_d     = StFetch;
        end
      end
      StFetch: begin
        // Address is held from the latched miss, so a flushed fetch still completes.
        iren  = 1'b1;
        iaddr = miss_addr_q;
        if (!bus.iwait) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (RST) begin
      ihit     = 1'b0;
      imemload = '0;
      iren     = 1'b0;
      iaddr    = '0;
      fill     = 1'b0;
    end
  end

  assign bus.ihit     = ihit;
  assign bus.imemload = imemload;
  assign bus.iREN     = iren;
  assign bus.iaddr    = iaddr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Invalidate takes priority over a same-cycle fill.
  always_ff @(posedge CLK) begin
    if (RST || bus.inv) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if ((state_q == StIdle) && (state_d == StFetch) && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.imemaddr[1:0], miss_addr_q[1:0]};
endmodule

// File: tb/tb_icache_responder.sv
// Directed table-driven bench for icache_responder (SETS=16), plus a reset-mid-fetch sequence.
module tb_icache_responder;
  logic CLK;
  logic RST;
  icache_responder_if bus ();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_responder #(.SETS(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        inv;
    logic        iwait;
    logic [31:0] iload;
    logic        exp_ihit;
    logic [31:0] exp_load;
    logic        exp_iren;
    logic [31:0] exp_iaddr;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(logic rst, logic ren, logic [31:0] addr, logic inv, logic iwait,
                              logic [31:0] iload, logic eh, logic [31:0] el, logic er,
                              logic [31:0] ea);
    vec_t v;
    v.rst = rst; v.ren = ren; v.addr = addr; v.inv = inv; v.iwait = iwait; v.iload = iload;
    v.exp_ihit = eh; v.exp_load = el; v.exp_iren = er; v.exp_iaddr = ea;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic ren, logic [31:0] addr, logic inv, logic iwait,
                       logic [31:0] iload);
    RST = rst; bus.imemREN = ren; bus.imemaddr = addr; bus.inv = inv;
    bus.iwait = iwait; bus.iload = iload;
  endtask

  task automatic check_outs(string tag, logic eh, logic [31:0] el, logic er, logic [31:0] ea);
    check({tag, ".ihit"}, {31'd0, bus.ihit}, {31'd0, eh});
    check({tag, ".imemload"}, bus.imemload, el);
    check({tag, ".iREN"}, {31'd0, bus.iREN}, {31'd0, er});
    check({tag, ".iaddr"}, bus.iaddr, ea);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset
    vecs[0]  = mk(1, 1, 32'h40,  0, 1, 0,            0, 0,            0, 0);
    // cold miss on 0x40, two wait cycles, fill, hit four cycles after request
    vecs[1]  = mk(0, 1, 32'h40,  0, 1, 0,            0, 0,            0, 0);
    vecs[2]  = mk(0, 1, 32'h40,  0, 1, 0,            0, 0,            1, 32'h40);
    vecs[3]  = mk(0, 1, 32'h40,  0, 1, 0,            0, 0,            1, 32'h40);
    vecs[4]  = mk(0, 1, 32'h40,  0, 0, 32'h2008_0001, 0, 0,           1, 32'h40);
    vecs[5]  = mk(0, 1, 32'h40,  0, 1, 0,            1, 32'h2008_0001, 0, 0);
    vecs[6]  = mk(0, 1, 32'h40,  0, 1, 0,            1, 32'h2008_0001, 0, 0);
    // conflict on index 0: 0x440 evicts 0x40, then 0x40 misses again
    vecs[7]  = mk(0, 1, 32'h440, 0, 0, 0,            0, 0,            0, 0);
    vecs[8]  = mk(0, 1, 32'h440, 0, 0, 32'hAAAA_0440, 0, 0,           1, 32'h440);
    vecs[9]  = mk(0, 1, 32'h440, 0, 1, 0,            1, 32'hAAAA_0440, 0, 0);
    vecs[10] = mk(0, 1, 32'h40,  0, 0, 0,            0, 0,            0, 0);
    vecs[11] = mk(0, 1, 32'h40,  0, 0, 32'h2008_0001, 0, 0,           1, 32'h40);
    vecs[12] = mk(0, 1, 32'h40,  0, 1, 0,            1, 32'h2008_0001, 0, 0);
    // flush mid-fetch: address moves to 0x200, fetch of 0x100 still completes
    vecs[13] = mk(0, 1, 32'h100, 0, 1, 0,            0, 0,            0, 0);
    vecs[14] = mk(0, 1, 32'h200, 0, 1, 0,            0, 0,            1, 32'h100);
    vecs[15] = mk(0, 0, 32'h200, 0, 1, 0,            0, 0,            1, 32'h100);
    vecs[16] = mk(0, 1, 32'h200, 0, 0, 32'h1111_0100, 0, 0,           1, 32'h100);
    vecs[17] = mk(0, 1, 32'h100, 0, 1, 0,            1, 32'h1111_0100, 0, 0);
    vecs[18] = mk(0, 1, 32'h200, 0, 1, 0,            0, 0,            0, 0);
    vecs[19] = mk(0, 1, 32'h200, 0, 0, 32'h2222_0200, 0, 0,           1, 32'h200);
    vecs[20] = mk(0, 0, 32'h200, 0, 1, 0,            0, 0,            0, 0);
    vecs[21] = mk(0, 1, 32'h200, 0, 1, 0,            1, 32'h2222_0200, 0, 0);
    // invalidate: fill 0x40 and 0x44, inv with a hit, then inv on a fill cycle
    vecs[22] = mk(0, 1, 32'h40,  0, 1, 0,            0, 0,            0, 0);
    vecs[23] = mk(0, 1, 32'h40,  0, 0, 32'h3333_0040, 0, 0,           1, 32'h40);
    vecs[24] = mk(0, 1, 32'h44,  0, 1, 0,            0, 0,            0, 0);
    vecs[25] = mk(0, 1, 32'h44,  0, 0, 32'h4444_0044, 0, 0,           1, 32'h44);
    vecs[26] = mk(0, 1, 32'h44,  1, 1, 0,            1, 32'h4444_0044, 0, 0);
    vecs[27] = mk(0, 1, 32'h44,  0, 1, 0,            0, 0,            0, 0);
    vecs[28] = mk(0, 1, 32'h44,  1, 0, 32'h5555_0044, 0, 0,           1, 32'h44);
    vecs[29] = mk(0, 1, 32'h44,  0, 1, 0,            0, 0,            0, 0);
    vecs[30] = mk(0, 1, 32'h44,  0, 0, 32'h5555_0044, 0, 0,           1, 32'h44);
    vecs[31] = mk(0, 1, 32'h40,  0, 1, 0,            0, 0,            0, 0);
    vecs[32] = mk(0, 1, 32'h40,  0, 0, 32'h3333_0040, 0, 0,           1, 32'h40);
    vecs[33] = mk(0, 1, 32'h40,  0, 1, 0,            1, 32'h3333_0040, 0, 0);

    drive(1, 0, 0, 0, 1, 0);
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].ren, vecs[i].addr, vecs[i].inv, vecs[i].iwait, vecs[i].iload);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_ihit, vecs[i].exp_load,
                 vecs[i].exp_iren, vecs[i].exp_iaddr);
      tick();
    end

    // reset mid-fetch: transaction dropped, previously cached 0x40 misses afterwards
    drive(0, 1, 32'h80, 0, 1, 0);
    tick();
    #2;
    check_outs("rst.fetch", 0, 0, 1, 32'h80);
    drive(1, 1, 32'h80, 0, 1, 0);
    #2;
    check_outs("rst.forced", 0, 0, 0, 0);
    tick();
    drive(0, 0, 32'h80, 0, 1, 0);
    #2;
    check_outs("rst.after", 0, 0, 0, 0);
`ifdef ICACHE_STATS_EN
    check("stats.rst_hit", hit_count, 0);
    check("stats.rst_miss", miss_count, 0);
`endif
    tick();
    drive(0, 1, 32'h40, 0, 0, 32'h6666_0040);
    #2;
    check_outs("rst.miss40", 0, 0, 0, 0);
    tick();
    #2;
    check_outs("rst.fill40", 0, 0, 1, 32'h40);
    tick();
    for (int k = 0; k < 3; k++) begin
      #2;
      check_outs($sformatf("rst.hit40_%0d", k), 1, 32'h6666_0040, 0, 0);
      tick();
    end
    drive(0, 0, 32'h40, 0, 1, 0);
    #2;
    check_outs("rst.idle", 0, 0, 0, 0);
`ifdef ICACHE_STATS_EN
    check("stats.hit", hit_count, 3);
    check("stats.miss", miss_count, 1);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
